// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: command codes, FSM state encoding and command helpers.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    CMD_ADD  = 4'd0,
    CMD_SUB  = 4'd1,
    CMD_XOR  = 4'd2,
    CMD_SLT  = 4'd3,
    CMD_AND  = 4'd4,
    CMD_NAND = 4'd5,
    CMD_NOR  = 4'd6,
    CMD_OR   = 4'd7,
    CMD_SLL  = 4'd8,
    CMD_SRL  = 4'd9,
    CMD_SRA  = 4'd10
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic isIllegalCmd(input logic [3:0] cmd);
    return cmd > 4'd10;
  endfunction

  function automatic logic isShiftCmd(input logic [3:0] cmd);
    return (cmd == CMD_SLL) || (cmd == CMD_SRL) || (cmd == CMD_SRA);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/command and result handshake bundle between decode, seq_alu and writeback.
interface seq_alu_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [3:0]       command;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             cmd_err;

  modport master (
    output in_valid, operandA, operandB, command, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero, cmd_err
  );

  modport slave (
    input  in_valid, operandA, operandB, command, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero, cmd_err
  );

endinterface

// File: rtl/seq_alu_shift_unit.sv
// Shifter for seq_alu: iterative one-bit-per-clock by default, single-cycle barrel
// shifter when ALU_BARREL_SHIFT_EN is defined.
module seq_alu_shift_unit
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_value,
  input  logic [SHW-1:0]   i_amount,
  input  cmd_e             i_mode,
  output logic             o_done,
  output logic [WIDTH-1:0] o_value
);

`ifdef ALU_BARREL_SHIFT_EN

  logic w_unusedBarrel;
  assign w_unusedBarrel = ^{i_start, clock, reset_n};

  always_comb begin
    o_value = '0;
    case (i_mode)
      CMD_SLL: o_value = i_value << i_amount;
      CMD_SRL: o_value = i_value >> i_amount;
      default: o_value = $signed(i_value) >>> i_amount;
    endcase
  end

  assign o_done = 1'b1;

`else

  logic [WIDTH-1:0] r_shReg;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  cmd_e             r_mode;
  logic [WIDTH-1:0] w_step;

  always_comb begin
    w_step = '0;
    case (r_mode)
      CMD_SLL: w_step = {r_shReg[WIDTH-2:0], 1'b0};
      CMD_SRL: w_step = {1'b0, r_shReg[WIDTH-1:1]};
      default: w_step = {r_shReg[WIDTH-1], r_shReg[WIDTH-1:1]};
    endcase
  end

  // The last step is presented combinationally so the top can register it on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shReg <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_mode  <= CMD_SLL;
    end else if (i_start) begin
      r_shReg <= i_value;
      r_cnt   <= i_amount;
      r_busy  <= 1'b1;
      r_mode  <= i_mode;
    end else if (r_busy) begin
      r_shReg <= w_step;
      r_cnt   <= r_cnt - SHW'(1);
      if (r_cnt == SHW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_done  = r_busy && (r_cnt == SHW'(1));
  assign o_value = w_step;

`endif

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result; shift latency depends on ALU_BARREL_SHIFT_EN
// (defined: single-cycle barrel shifter, undefined: iterative shifter with SHIFT state).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic      clock,
  input  logic      reset_n,
  seq_alu_if.slave  bus
);

  logic             w_accept;
  logic             w_inReady;
  logic             w_isShift;
  logic             w_illegal;
  logic             w_isSub;
  logic             w_longShift;
  logic [SHW-1:0]   w_amount;
  logic [WIDTH-1:0] w_bOp;
  logic [WIDTH:0]   w_sum;
  logic             w_ovfRaw;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_shDone;
  logic [WIDTH-1:0] w_shValue;

  logic [WIDTH-1:0] r_result;
  logic             r_outValid;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_cmdErr;

  assign w_accept  = bus.in_valid && w_inReady;
  assign w_isShift = isShiftCmd(bus.command);
  assign w_illegal = isIllegalCmd(bus.command);
  assign w_amount  = bus.operandB[SHW-1:0];

  // SLT reuses the subtract path; the sign of A-B corrected by overflow gives signed less-than.
  assign w_isSub  = (bus.command == CMD_SUB) || (bus.command == CMD_SLT);
  assign w_bOp    = w_isSub ? ~bus.operandB : bus.operandB;
  assign w_sum    = {1'b0, bus.operandA} + {1'b0, w_bOp} + (WIDTH+1)'(w_isSub);
  assign w_ovfRaw = (bus.operandA[WIDTH-1] == w_bOp[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != bus.operandA[WIDTH-1]);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.command)
      CMD_ADD, CMD_SUB: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_ovfRaw;
      end
      CMD_XOR:  w_res = bus.operandA ^ bus.operandB;
      CMD_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovfRaw};
      CMD_AND:  w_res = bus.operandA & bus.operandB;
      CMD_NAND: w_res = ~(bus.operandA & bus.operandB);
      CMD_NOR:  w_res = ~(bus.operandA | bus.operandB);
      CMD_OR:   w_res = bus.operandA | bus.operandB;
`ifdef ALU_BARREL_SHIFT_EN
      CMD_SLL, CMD_SRL, CMD_SRA: w_res = w_shValue;
`else
      CMD_SLL, CMD_SRL, CMD_SRA: w_res = bus.operandA;
`endif
      default:  w_res = '0;
    endcase
  end

  seq_alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_start  (w_accept && w_longShift),
    .i_value  (bus.operandA),
    .i_amount (w_amount),
    .i_mode   (cmd_e'(bus.command)),
    .o_done   (w_shDone),
    .o_value  (w_shValue)
  );

`ifdef ALU_BARREL_SHIFT_EN

  logic w_unusedDone;
  assign w_unusedDone = w_shDone;
  assign w_longShift  = 1'b0;
  assign w_inReady    = !r_outValid || bus.out_ready;

`else

  state_e r_state;
  state_e w_nextState;

  assign w_longShift = w_isShift && (w_amount != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_inReady = !r_outValid || bus.out_ready;
        if (w_accept && w_longShift) w_nextState = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_shDone) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

`endif

  // A new accept takes priority over retiring the old result, enabling back-to-back issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result   <= '0;
      r_outValid <= 1'b0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
      r_cmdErr   <= 1'b0;
    end else if (w_accept && !w_longShift) begin
      r_result   <= w_res;
      r_outValid <= 1'b1;
      r_carry    <= w_carry;
      r_ovf      <= w_ovf;
      r_zero     <= (w_res == '0);
      r_cmdErr   <= w_illegal;
`ifndef ALU_BARREL_SHIFT_EN
    end else if ((r_state == ST_SHIFT) && w_shDone) begin
      r_result   <= w_shValue;
      r_outValid <= 1'b1;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= (w_shValue == '0);
      r_cmdErr   <= 1'b0;
`endif
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.result    = r_result;
  assign bus.carryout  = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.cmd_err   = r_cmdErr;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); expected shift latency follows
// ALU_BARREL_SHIFT_EN.
module tb_seq_alu;
  import seq_alu_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit ITER = 1'b0;
`else
  localparam bit ITER = 1'b1;
`endif

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one operation and returns one time unit after its accept edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cmd);
    int guard;
    bus.operandA = a;
    bus.operandB = b;
    bus.command  = cmd;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    checkOutput("acceptReady", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitValid(output int edges, output int readySeen);
    edges     = 0;
    readySeen = 0;
    while (!bus.out_valid && edges < 100) begin
      if (bus.in_ready) readySeen++;
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic checkShift(input string tag, input logic [31:0] a, input logic [4:0] n,
                            input logic [3:0] cmd, input logic [31:0] expected);
    int edges;
    int readySeen;
    applyStimulus(a, {27'd0, n}, cmd);
    waitValid(edges, readySeen);
    checkOutput({tag, "_latency"}, edges, (ITER && n != 0) ? 32'(n) : 32'd0);
    checkOutput({tag, "_busyReady"}, readySeen, 32'd0);
    checkOutput({tag, "_result"}, bus.result, expected);
    checkOutput({tag, "_flags"}, {28'd0, bus.carryout, bus.overflow, bus.zero, bus.cmd_err},
                {28'd0, 3'b000, (expected == 0), 1'b0});
  endtask

  logic [31:0] logicA;
  logic [31:0] logicB;
  logic [3:0]  logicCmd [5];
  logic [31:0] logicExp [5];

  initial begin
    int staleSeen;
    checks        = 0;
    failures      = 0;
    bus.in_valid  = 1'b0;
    bus.operandA  = '0;
    bus.operandB  = '0;
    bus.command   = '0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    #2;
    checkOutput("resetValid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("resetReady", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("resetResult", bus.result, 32'd0);
    checkOutput("resetFlags", {28'd0, bus.carryout, bus.overflow, bus.zero, bus.cmd_err}, 32'd0);
    #11 reset_n = 1'b1;
    @(posedge clock); #1;

    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, CMD_ADD);
    checkOutput("addValid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("addResult", bus.result, 32'h0000_0000);
    checkOutput("addFlags", {28'd0, bus.carryout, bus.overflow, bus.zero, bus.cmd_err}, 32'b1010);

    applyStimulus(32'h8000_0000, 32'h0000_0001, CMD_SUB);
    checkOutput("subResult", bus.result, 32'h7FFF_FFFF);
    checkOutput("subFlags", {28'd0, bus.carryout, bus.overflow, bus.zero, bus.cmd_err}, 32'b1100);

    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, CMD_SLT);
    checkOutput("sltResult", bus.result, 32'h0000_0001);
    checkOutput("sltFlags", {28'd0, bus.carryout, bus.overflow, bus.zero, bus.cmd_err}, 32'b0000);

    applyStimulus(32'h0000_0005, 32'hFFFF_FFFD, CMD_SLT);
    checkOutput("sltPosNeg", bus.result, 32'h0000_0000);

    logicA = 32'hF0F0_F0F0;
    logicB = 32'hFF00_FF00;
    logicCmd[0] = CMD_XOR;  logicExp[0] = 32'h0FF0_0FF0;
    logicCmd[1] = CMD_AND;  logicExp[1] = 32'hF000_F000;
    logicCmd[2] = CMD_NAND; logicExp[2] = 32'h0FFF_0FFF;
    logicCmd[3] = CMD_NOR;  logicExp[3] = 32'h000F_000F;
    logicCmd[4] = CMD_OR;   logicExp[4] = 32'hFFF0_FFF0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(logicA, logicB, logicCmd[i]);
      checkOutput($sformatf("logic%0d", i), bus.result, logicExp[i]);
    end

    checkShift("sra4", 32'h8000_0000, 5'd4, CMD_SRA, 32'hF800_0000);
    checkShift("srl4", 32'h8000_0000, 5'd4, CMD_SRL, 32'h0800_0000);
    checkShift("sll3", 32'h0000_0003, 5'd3, CMD_SLL, 32'h0000_0018);
    checkShift("sll0", 32'h1234_5678, 5'd0, CMD_SLL, 32'h1234_5678);

    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    applyStimulus(32'h0000_0005, 32'h0000_0007, CMD_ADD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("stallResult%0d", i), bus.result, 32'd12);
      checkOutput($sformatf("stallState%0d", i), {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
    end
    bus.operandA  = 32'd10;
    bus.operandB  = 32'd3;
    bus.command   = CMD_SUB;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("b2bReady", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    checkOutput("b2bResult", bus.result, 32'd7);
    checkOutput("b2bValid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clock); #1;
    checkOutput("b2bDrain", {31'd0, bus.out_valid}, 32'd0);

    applyStimulus(32'h0000_0001, 32'd31, CMD_SLL);
    repeat (21) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    checkOutput("abortValid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("abortReady", {31'd0, bus.in_ready}, 32'd1);
    #2 reset_n = 1'b1;
    staleSeen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.out_valid) staleSeen++;
    end
    checkOutput("abortNoStale", staleSeen, 32'd0);
    checkOutput("abortIdleReady", {31'd0, bus.in_ready}, 32'd1);

    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 4'd13);
    checkOutput("illegalValid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("illegalResult", bus.result, 32'd0);
    checkOutput("illegalFlags", {28'd0, bus.carryout, bus.overflow, bus.zero, bus.cmd_err}, 32'b0011);

    applyStimulus(32'd1, 32'd1, CMD_ADD);
    checkOutput("afterIllegal", {bus.result[27:0], bus.carryout, bus.overflow, bus.zero, bus.cmd_err},
                {28'd2, 4'b0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
